// File: rtl/uart_mon_cmd.sv
// uart_mon_cmd -- line-oriented monitor command parser behind a UART.
//
// Pops ASCII bytes from the rx FIFO, optionally echoes them, and parses
//   r <addr>\r          -> one bus read, reply "<DATA_W/4 hex digits>\r\n"
//   w <addr> <data>\r   -> one bus write, reply "\r\n"
// Malformed lines are answered with "?\r\n" once their CR arrives.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   rx_fifo_dvalid  rx FIFO non-empty, rx_rdata is the head byte
//   rx_rden         1-cycle pop pulse; the byte is captured in that cycle
//   tx_fifo_full    tx FIFO cannot take a byte
//   tx_wten/wdata   1-cycle push of one byte
//   bus_req/we/addr/wdata  request, held (and stable) until bus_ack
//   bus_ack/rdata   1-cycle completion, read data valid with it
//   busy            parser is not in S_IDLE
module uart_mon_cmd #(
  parameter int ECHO   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_fifo_dvalid,
  input  logic [7:0]        rx_rdata,
  output logic              rx_rden,
  input  logic              tx_fifo_full,
  output logic              tx_wten,
  output logic [7:0]        tx_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_QM = 8'h3F;
  localparam logic [2:0] HEX_LAST = 3'(DATA_W / 4 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SP1, S_ADDR, S_DATA, S_BUS, S_HEX, S_QM, S_CRLF, S_ERR
  } state_t;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // 'A'/'a' have low nibble 1, so adding 9 maps both cases onto 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          byte_q, byte_d;       // byte popped last cycle
  logic                have_q, have_d;       // byte_q awaits processing
  logic                we_q, we_d;
  logic                digit_q, digit_d;     // current field has >= 1 digit
  logic [ADDR_W-1:0]   acc_a_q, acc_a_d;
  logic [DATA_W-1:0]   acc_d_q, acc_d_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          idx_q, idx_d;         // hex nibble being sent
  logic                pend_q, pend_d;       // one tx byte waiting for room
  logic [7:0]          pend_byte_q, pend_byte_d;
  logic                pend_lf_q, pend_lf_d; // follow pend byte with LF
  logic                bus_req_q, bus_req_d;

  logic                consume;
  state_t              err_state;
  logic [3:0]          rd_nib;

  // A bad CR already ends the line, so it goes straight to the '?' reply
  // instead of waiting in S_ERR for a CR that has been consumed.
  assign err_state = (byte_q == CH_CR) ? S_QM : S_ERR;
  assign consume   = state_q inside {S_IDLE, S_SP1, S_ADDR, S_DATA, S_ERR};
  assign rd_nib    = 4'(rdata_q >> {idx_q, 2'b00});

  // Only pop when the echo of this byte is guaranteed a free pend slot.
  assign rx_rden   = ~rst & rx_fifo_dvalid & ~tx_fifo_full & ~pend_q &
                     ~have_q & consume;
  assign tx_wten   = pend_q & ~tx_fifo_full;
  assign tx_wdata  = pend_byte_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = we_q;
  assign bus_addr  = acc_a_q;
  assign bus_wdata = acc_d_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every _d starts at its hold value so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    byte_d      = byte_q;
    have_d      = have_q;
    we_d        = we_q;
    digit_d     = digit_q;
    acc_a_d     = acc_a_q;
    acc_d_d     = acc_d_q;
    rdata_d     = rdata_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    pend_lf_d   = pend_lf_q;
    bus_req_d   = bus_req_q;

    // Drain the pend slot; a CR echo turns into an LF after leaving.
    if (pend_q && !tx_fifo_full) begin
      if (pend_lf_q) begin
        pend_byte_d = CH_LF;
        pend_lf_d   = 1'b0;
      end else begin
        pend_d = 1'b0;
      end
    end

    if (rx_rden) begin
      byte_d = rx_rdata;
      have_d = 1'b1;
    end

    if (have_q) begin
      have_d = 1'b0;
      if (ECHO != 0) begin
        pend_d      = 1'b1;
        pend_byte_d = byte_q;
        pend_lf_d   = (byte_q == CH_CR);
      end
    end

    unique case (state_q)
      S_IDLE: if (have_q) begin
        if (byte_q == 8'h72 || byte_q == 8'h52 ||
            byte_q == 8'h77 || byte_q == 8'h57) begin
          we_d    = (byte_q == 8'h77 || byte_q == 8'h57);
          acc_a_d = '0;
          acc_d_d = '0;
          state_d = S_SP1;
        end else if (!(byte_q == CH_CR || byte_q == CH_LF || byte_q == CH_SP)) begin
          state_d = err_state;
        end
      end
      S_SP1: if (have_q) begin
        digit_d = 1'b0;
        state_d = (byte_q == CH_SP) ? S_ADDR : err_state;
      end
      S_ADDR: if (have_q) begin
        if (is_hex(byte_q)) begin
          acc_a_d = ADDR_W'({acc_a_q, hex_val(byte_q)});
          digit_d = 1'b1;
        end else if (byte_q == CH_SP) begin
          if (digit_q) begin
            digit_d = 1'b0;
            state_d = we_q ? S_DATA : S_ERR;
          end
        end else if (byte_q == CH_CR && digit_q && !we_q) begin
          bus_req_d = 1'b1;
          state_d   = S_BUS;
        end else begin
          state_d = err_state;
        end
      end
      S_DATA: if (have_q) begin
        if (is_hex(byte_q)) begin
          acc_d_d = DATA_W'({acc_d_q, hex_val(byte_q)});
          digit_d = 1'b1;
        end else if (byte_q == CH_CR && digit_q) begin
          bus_req_d = 1'b1;
          state_d   = S_BUS;
        end else if (!(byte_q == CH_SP && !digit_q)) begin
          state_d = err_state;
        end
      end
      S_ERR: if (have_q && byte_q == CH_CR) state_d = S_QM;
      S_BUS: if (bus_ack) begin
        bus_req_d = 1'b0;
        if (!we_q) begin
          rdata_d = bus_rdata;
          idx_d   = HEX_LAST;
          state_d = S_HEX;
        end else begin
          state_d = S_CRLF;
        end
      end
      S_HEX: if (!pend_q) begin
        pend_d      = 1'b1;
        pend_byte_d = hex_chr(rd_nib);
        pend_lf_d   = 1'b0;
        if (idx_q == 3'd0) state_d = S_CRLF;
        else               idx_d   = idx_q - 3'd1;
      end
      S_QM: if (!pend_q) begin
        pend_d      = 1'b1;
        pend_byte_d = CH_QM;
        pend_lf_d   = 1'b0;
        state_d     = S_CRLF;
      end
      S_CRLF: if (!pend_q) begin
        pend_d      = 1'b1;
        pend_byte_d = CH_CR;
        pend_lf_d   = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_q      <= '0;
      have_q      <= 1'b0;
      we_q        <= 1'b0;
      digit_q     <= 1'b0;
      acc_a_q     <= '0;
      acc_d_q     <= '0;
      rdata_q     <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      pend_lf_q   <= 1'b0;
      bus_req_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register sees its peers' pre-edge values.
      state_q     <= state_d;
      byte_q      <= byte_d;
      have_q      <= have_d;
      we_q        <= we_d;
      digit_q     <= digit_d;
      acc_a_q     <= acc_a_d;
      acc_d_q     <= acc_d_d;
      rdata_q     <= rdata_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      pend_lf_q   <= pend_lf_d;
      bus_req_q   <= bus_req_d;
    end
  end

endmodule

// File: tb/tb_uart_mon_cmd.sv
// Bench for uart_mon_cmd: a queue-backed rx FIFO, a tx scoreboard of
// expected bytes, and a bus responder that checks each request against an
// expected-transaction queue and acks three cycles after it rises.
module tb_uart_mon_cmd;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    string       cmd;
    bit          has_bus;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    string       reply;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_fifo_dvalid = 1'b0;
  logic [7:0]  rx_rdata = 8'h00;
  logic        rx_rden;
  logic        tx_fifo_full = 1'b0;
  logic        tx_wten;
  logic [7:0]  tx_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   stall_viol = 0;
  bit   hold_ack = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  bus_t       bus_exp[$];

  uart_mon_cmd #(.ECHO(1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rx_fifo_dvalid(rx_fifo_dvalid), .rx_rdata(rx_rdata), .rx_rden(rx_rden),
    .tx_fifo_full(tx_fifo_full), .tx_wten(tx_wten), .tx_wdata(tx_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h, expected no such event", name, act);
  endtask

  // Queue a command line: rx bytes, its echo (CR echoes as CR LF), the
  // reply, and the bus transaction it should produce.
  task automatic send(input string cmd, input string reply,
                      input bit has_bus, input bus_t b);
    for (int i = 0; i < cmd.len(); i++) begin
      rx_q.push_back(cmd[i]);
      tx_exp.push_back(cmd[i]);
      if (cmd[i] == 8'h0D) tx_exp.push_back(8'h0A);
    end
    for (int i = 0; i < reply.len(); i++) tx_exp.push_back(reply[i]);
    if (has_bus) bus_exp.push_back(b);
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (!(rx_q.size() == 0 && tx_exp.size() == 0 && !busy && !bus_req)
           && cyc < budget) begin
      @(negedge clk); #2;
      cyc++;
    end
    check({name, " completes"}, cyc < budget, 1'b1);
    check({name, " bus consumed"}, bus_exp.size(), 0);
  endtask

  // FIFO model, tx scoreboard and bus responder. Samples at the falling
  // edge, updates FIFO inputs just after the rising edge.
  always begin : monitor
    bit   pop_pend;
    bit   prev_rden;
    int   req_cnt;
    bus_t cur;
    logic [7:0] exp_b;
    @(negedge clk);
    pop_pend = 1'b0;
    if (!rst) begin
      if (rx_rden) begin
        check("pop spacing", prev_rden, 1'b0);
        pop_pend = 1'b1;
      end
      prev_rden = rx_rden;
      if (tx_wten) begin
        check("push while full", tx_fifo_full, 1'b0);
        if (tx_exp.size() == 0) fail_now("tx unexpected byte", tx_wdata);
        else begin
          exp_b = tx_exp.pop_front();
          check("tx byte", tx_wdata, exp_b);
        end
      end
      if (tx_fifo_full && (rx_rden || tx_wten)) stall_viol++;
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (bus_exp.size() == 0) fail_now("bus unexpected req", bus_addr);
          else begin
            cur = bus_exp.pop_front();
            check("bus_we", bus_we, cur.we);
            check("bus_addr", bus_addr, cur.addr);
            if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
          end
        end else begin
          check("bus_addr stable", bus_addr, cur.addr);
        end
        if (req_cnt == 3 && !hold_ack) begin
          bus_rdata = cur.rdata;
          bus_ack   = 1'b1;
        end
      end else begin
        req_cnt = 0;
      end
    end else begin
      prev_rden = 1'b0;
      req_cnt   = 0;
    end
    @(posedge clk); #1;
    if (pop_pend && rx_q.size() != 0) void'(rx_q.pop_front());
    bus_ack        = 1'b0;
    rx_fifo_dvalid = (rx_q.size() != 0);
    rx_rdata       = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[10];
    bus_t b;
    int   cyc;
    int   sz;
    string c2;

    vec[0] = '{"r 10\015",        1, 0, 32'h10,       32'h0,        32'h1234ABCD, "1234ABCD\015\012"};
    vec[1] = '{"w 20 DEADbeef\015", 1, 1, 32'h20,     32'hDEADBEEF, 32'h0,        "\015\012"};
    vec[2] = '{"x 5\015",         0, 0, 32'h0,        32'h0,        32'h0,        "?\015\012"};
    vec[3] = '{"r\015",           0, 0, 32'h0,        32'h0,        32'h0,        "?\015\012"};
    vec[4] = '{"r 123456789\015", 1, 0, 32'h23456789, 32'h0,        32'h00000000, "00000000\015\012"};
    vec[5] = '{"r 5 6\015",       0, 0, 32'h0,        32'h0,        32'h0,        "?\015\012"};
    vec[6] = '{"w 1\015",         0, 0, 32'h0,        32'h0,        32'h0,        "?\015\012"};
    vec[7] = '{"w 3  9\015",      1, 1, 32'h3,        32'h9,        32'h0,        "\015\012"};
    vec[8] = '{" \012R ff\015",   1, 0, 32'hFF,       32'h0,        32'h89ABCDEF, "89ABCDEF\015\012"};
    vec[9] = '{"w 4 \015",        0, 0, 32'h0,        32'h0,        32'h0,        "?\015\012"};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("reset rx_rden", rx_rden, 0);
    check("reset tx_wten", tx_wten, 0);
    check("reset tx_wdata", tx_wdata, 0);
    check("reset bus_req", bus_req, 0);
    check("reset bus_we", bus_we, 0);
    check("reset bus_addr", bus_addr, 0);
    check("reset bus_wdata", bus_wdata, 0);
    check("reset busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Table of command lines.
    for (int i = 0; i < 10; i++) begin
      b = '{we: vec[i].we, addr: vec[i].addr, wdata: vec[i].wdata,
            rdata: vec[i].rdata};
      send(vec[i].cmd, vec[i].reply, vec[i].has_bus, b);
      wait_done($sformatf("vec%0d", i), 600);
    end

    // tx FIFO full for 1000 cycles in the middle of a hex reply, with the
    // next command already waiting in the rx FIFO.
    send("r 10\015", "CAFE0123\015\012", 1, '{0, 32'h10, 32'h0, 32'hCAFE0123});
    cyc = 0;
    while (tx_exp.size() > 8 && cyc < 600) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("stall reaches mid-reply", cyc < 600, 1'b1);
    @(posedge clk); #2;
    tx_fifo_full = 1'b1;
    c2 = "r 4\015";
    send(c2, "00000042\015\012", 1, '{0, 32'h4, 32'h0, 32'h00000042});
    sz = tx_exp.size();
    stall_viol = 0;
    repeat (1000) @(posedge clk);
    #2;
    check("stall no traffic", stall_viol, 0);
    check("stall tx untouched", tx_exp.size(), sz);
    check("stall rx untouched", rx_q.size(), c2.len());
    tx_fifo_full = 1'b0;
    wait_done("stall release", 800);

    // Reset while a bus request is outstanding.
    hold_ack = 1'b1;
    send("r 44\015", "", 1, '{0, 32'h44, 32'h0, 32'h0});
    cyc = 0;
    while (!bus_req && cyc < 600) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("midreset req seen", bus_req, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    rx_q.delete();
    tx_exp.delete();
    bus_exp.delete();
    @(negedge clk); #2;
    check("midreset bus_req", bus_req, 0);
    check("midreset tx_wten", tx_wten, 0);
    check("midreset rx_rden", rx_rden, 0);
    check("midreset busy", busy, 0);
    check("midreset bus_addr", bus_addr, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    hold_ack = 1'b0;
    send("r 0\015", "000000F0\015\012", 1, '{0, 32'h0, 32'h0, 32'h000000F0});
    wait_done("after reset", 600);

    // Nothing further may be pushed once idle.
    repeat (20) @(posedge clk);
    #2;
    check("final tx queue empty", tx_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
